pipe_feeder: RTL

Producer side of the pipe queue. Generates the gap position of each new pipe from an LFSR and issues the one-cycle shift strobe that pushes it into the 8-entry × 16-bit pipe shift register. It also owns horizontal scroll timing, so pipes enter the queue every PITCH pixels of scroll. It sits between the frame-tick/game-control logic and the pipe queue; collision and render blocks read the queue, not this block.

---
 rtl/pipe_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_feeder.sv
// -----------------------------------------------------------------------------
// pipe_feeder
//
// Producer side of the pipe queue. A 16-bit Galois LFSR supplies the gap low
// edge of each new pipe (folded into [Y_MIN, Y_MAX]), and a one-cycle
// shift_en strobe pushes it into the downstream 8 x 16-bit pipe shift
// register. The block also owns horizontal scroll timing: a new pipe enters
// the queue every PITCH scroll ticks while the game runs. On start it emits
// PRIME_N back-to-back pipes so the whole queue is refilled.
//
// Ports
//   clk            in   1   clock
//   rst            in   1   asynchronous, active-high reset
//   tick           in   1   one-cycle frame/scroll pulse
//   start          in   1   begin or restart a game
//   crash          in   1   collision detected
//   nxt_pipe       out 16   gap low edge offered to the queue (combinational
//                           function of the LFSR register)
//   shift_en       out  1   one-cycle strobe, drives the queue's enable
//   scroll_x       out 10   scroll offset within the current pitch
//   state          out  2   IDLE=0, PRIME=1, RUN=2, HALT=3
//   pipes_emitted  out 16   shift_en pulses since last start, saturating
// -----------------------------------------------------------------------------
module pipe_feeder #(
    parameter int unsigned GAP_H   = 90,
    parameter int unsigned Y_MIN   = 40,
    parameter int unsigned Y_MAX   = 350,
    parameter int unsigned PITCH   = 300,
    parameter int unsigned PRIME_N = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        crash,
    output logic [15:0] nxt_pipe,
    output logic        shift_en,
    output logic [9:0]  scroll_x,
    output logic [1:0]  state,
    output logic [15:0] pipes_emitted
);

    localparam int unsigned SPAN      = Y_MAX - Y_MIN;
    localparam logic [8:0]  SPAN_9    = 9'(SPAN);
    localparam logic [8:0]  FOLD_9    = 9'(SPAN + 1);
    localparam logic [15:0] Y_MIN_16  = 16'(Y_MIN);
    localparam logic [9:0]  PITCH_M1  = 10'(PITCH - 1);
    localparam logic [7:0]  PRIME_LAST = 8'(PRIME_N - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Parameter sanity: the fold only works for 255 <= SPAN <= 511, the
    // consumer's gap top must fit in 16 bits, and a zero seed locks the LFSR.
    if (SPAN < 255 || SPAN > 511 || PITCH < 2 || PRIME_N < 1 || PRIME_N > 256 ||
        SEED == 16'h0000 || (Y_MAX + GAP_H) > 65535) begin : g_param_check
        $error("pipe_feeder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] lfsr_q,      lfsr_d;
    logic [9:0]  scroll_q,    scroll_d;
    logic        shift_en_q,  shift_en_d;
    logic [7:0]  prime_cnt_q, prime_cnt_d;
    logic [15:0] pipes_q,     pipes_d;

    logic [8:0]  lfsr_low;
    logic [8:0]  gap_off;
    logic [15:0] lfsr_step;

    // Fold the 9-bit LFSR slice into 0..SPAN; one subtraction suffices
    // because SPAN >= 255 means r <= 511 < 2*(SPAN+1).
    always_comb begin
        lfsr_low = lfsr_q[8:0];
        gap_off  = (lfsr_low > SPAN_9) ? (lfsr_low - FOLD_9) : lfsr_low;
        nxt_pipe = Y_MIN_16 + {7'd0, gap_off};
    end

    always_comb begin
        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        scroll_d    = scroll_q;
        shift_en_d  = 1'b0;
        prime_cnt_d = prime_cnt_q;
        pipes_d     = pipes_q;

        // The pipe on offer is consumed on the edge closing a strobe cycle,
        // so the LFSR and the counter advance exactly then.
        if (shift_en_q) begin
            lfsr_d = lfsr_step;
            if (pipes_q != 16'hFFFF) begin
                pipes_d = pipes_q + 16'd1;
            end
        end

        case (state_q)
            IDLE, HALT: begin
                // start beats a simultaneous crash in HALT.
                if (start) begin
                    state_d     = PRIME;
                    scroll_d    = 10'd0;
                    pipes_d     = 16'd0;
                    prime_cnt_d = 8'd0;
                    shift_en_d  = 1'b1;
                end
            end
            PRIME: begin
                // prime_cnt_q counts strobes already on the wire; the entry
                // edge raised the first one.
                prime_cnt_d = prime_cnt_q + 8'd1;
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = RUN;
                end else begin
                    shift_en_d = 1'b1;
                end
            end
            RUN: begin
                // crash wins over tick: no scroll step, no strobe.
                if (crash) begin
                    state_d = HALT;
                end else if (tick) begin
                    if (scroll_q == PITCH_M1) begin
                        scroll_d   = 10'd0;
                        shift_en_d = 1'b1;
                    end else begin
                        scroll_d = scroll_q + 10'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            scroll_q    <= 10'd0;
            shift_en_q  <= 1'b0;
            prime_cnt_q <= 8'd0;
            pipes_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            scroll_q    <= scroll_d;
            shift_en_q  <= shift_en_d;
            prime_cnt_q <= prime_cnt_d;
            pipes_q     <= pipes_d;
        end
    end

    assign shift_en      = shift_en_q;
    assign scroll_x      = scroll_q;
    assign state         = state_q;
    assign pipes_emitted = pipes_q;

endmodule
